cipher_pipe: RTL and testbench
==============================

CIPHER_PIPE -- requirements
Module: cipher_pipe

Interface
REQ-001 SHALL have parameter LANES, default 1: number of 8-bit bytes per beat (1..8).
REQ-002 SHALL have parameter NKEY, default 3: number of rolling XOR key registers (1..8).
REQ-003 SHALL have port clock, input, 1 bit: the single clock; the block uses one clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port mode, input, 1 bit: 0 = encrypt, 1 = decrypt; sampled per accepted beat.
REQ-006 SHALL have port direction, input, 2 bits: 01 = forward Caesar, 10 = backward, 00/11 = no shift; sampled per beat.
REQ-007 SHALL have port shift_num, input, 5 bits: Caesar shift amount; sampled per beat.
REQ-008 SHALL have ports in_valid (input, 1 bit), in_ready (output, 1 bit) and din (input, 8*LANES bits): input beat handshake; lane i is din[8i+7:8i].
REQ-009 SHALL have ports out_valid (output, 1 bit), out_ready (input, 1 bit) and dout (output, 8*LANES bits): output beat handshake.
REQ-010 SHALL have ports key_we (input, 1 bit), key_idx (input, 3 bits) and key_data (input, 8 bits): key register write port.
REQ-011 SHALL have port key_sync, input, 1 bit: a pulse that rewinds the key pointer to 0.

Function
REQ-012 A beat SHALL be accepted when in_valid and in_ready are both high, and delivered when out_valid and out_ready are both high.
REQ-013 The pipeline SHALL have 3 register stages; latency from acceptance to out_valid SHALL be exactly 3 cycles when the pipe is unstalled.
REQ-014 in_ready SHALL equal out_ready OR NOT(the final stage holds valid data), giving full-throughput back-pressure with no bubbles.
REQ-015 A stalled stage SHALL hold its data and its sampled mode, direction, shift and key index unchanged.
REQ-016 Caesar shift amount SHALL be k = shift_num mod 26; shift_num values 26..31 map to 0..5.
REQ-017 Caesar shift SHALL apply only to bytes 0x41..0x5A and 0x61..0x7A, wrapping within the same case; all other byte values SHALL pass through unchanged.
REQ-018 Permutation P SHALL be out[7:0] = {in[0],in[5],in[2],in[6],in[7],in[4],in[3],in[1]}.
REQ-019 Inverse permutation Pinv SHALL be out[7:0] = {in[3],in[4],in[6],in[2],in[1],in[5],in[0],in[7]}.
REQ-020 In encrypt mode each lane SHALL pass through stage1 Caesar, then stage2 XOR key, then stage3 P.
REQ-021 In decrypt mode each lane SHALL pass through stage1 Pinv, then stage2 XOR key, then stage3 inverse Caesar (direction sense reversed).
REQ-022 Lane i of a beat SHALL use key[(ptr+i) mod NKEY]; ptr SHALL advance by LANES mod NKEY per accepted beat, wrapping at NKEY.
REQ-023 When key_sync and acceptance coincide, the beat SHALL use ptr = 0, and ptr afterwards SHALL be LANES mod NKEY.
REQ-024 A key_we write SHALL take effect for beats accepted on later cycles; beats already in flight SHALL keep the key value latched at stage 2 entry.
REQ-025 A key_we write with key_idx >= NKEY SHALL be ignored.
REQ-026 A key_we write and a stage-2 read of the same index in the same cycle SHALL yield the old value.

Reset
REQ-027 On rst, out_valid, all stage valid bits and ptr SHALL be cleared to 0.
REQ-028 On rst, dout SHALL be cleared to all zeros.
REQ-029 On rst, key[i] SHALL be loaded from the package default table: 0x3E, 0x49, 0x7E, then 0x00 for entries 3..7.
REQ-030 rst asserted mid-operation SHALL discard all in-flight beats with no partial output.
REQ-031 While rst is high, in_ready SHALL be 0.

Structure
REQ-032 Package cipher_pkg SHALL hold the letter-bound constants, the default key table, the direction encoding enum, and the P and Pinv functions.
REQ-033 Sub-module cipher_lane SHALL implement the per-byte datapath and SHALL be instantiated LANES times.
REQ-034 The key registers, key pointer and handshake control SHALL live in the top module.

Verification
REQ-035 Encrypt, LANES=1, din 0x41, direction 01, shift 3, after reset -> dout 0x57 three cycles after acceptance.
REQ-036 Decrypt 0x57, same settings -> dout 0x41; a 100-beat random encrypt-then-decrypt loop SHALL reproduce the original bytes.
REQ-037 Encrypt with direction 01, shift 29, din 0x7A and direction 00 -> Caesar output 0x63; byte 0x35 unchanged before XOR.
REQ-038 LANES=4, NKEY=3, two beats -> beat 1 uses keys 0,1,2,0 and beat 2 uses keys 1,2,0,1; key_sync before beat 2 -> keys 0,1,2,0.
REQ-039 Hold out_ready low for 5 cycles with in_valid high -> in_ready drops once full, no beat is lost or duplicated, and order is preserved.
REQ-040 Assert rst with 2 beats in flight -> out_valid is 0 the next cycle, and keys read back as defaults.

Source files
------------

// File: rtl/cipher_pkg.sv
// cipher_pkg: shared constants, default keys, direction encoding and byte transforms
// for the cipher pipeline.
package cipher_pkg;

   localparam logic [7:0] UC_LO = 8'h41;
   localparam logic [7:0] UC_HI = 8'h5A;
   localparam logic [7:0] LC_LO = 8'h61;
   localparam logic [7:0] LC_HI = 8'h7A;

   // key[i] = KEY_DEFAULT[8*i +: 8]
   localparam logic [63:0] KEY_DEFAULT = 64'h0000_0000_007E_493E;

   typedef enum logic [1:0] {
      DIR_NONE  = 2'b00,
      DIR_FWD   = 2'b01,
      DIR_BWD   = 2'b10,
      DIR_NONE2 = 2'b11
   } dir_e;

   function automatic logic [7:0] perm(input logic [7:0] b);
      return {b[0], b[5], b[2], b[6], b[7], b[4], b[3], b[1]};
   endfunction

   function automatic logic [7:0] perm_inv(input logic [7:0] b);
      return {b[3], b[4], b[6], b[2], b[1], b[5], b[0], b[7]};
   endfunction

   function automatic logic [2:0] wrap(input logic [4:0] v, input logic [4:0] n);
      return 3'(v % n);
   endfunction

   // inv flips the shift sense so the decrypt path undoes the encrypt shift
   function automatic logic [7:0] caesar(input logic [7:0] b, input logic [1:0] dir,
                                         input logic [4:0] sh, input logic inv);
      logic [4:0] k;
      logic [7:0] base;
      logic [5:0] off;
      logic       fwd;
      logic       lower;
      logic       letter;
      k      = (sh >= 5'd26) ? sh - 5'd26 : sh;
      fwd    = (dir == DIR_FWD) ^ inv;
      lower  = (b >= LC_LO) && (b <= LC_HI);
      letter = lower || ((b >= UC_LO) && (b <= UC_HI));
      base   = lower ? LC_LO : UC_LO;
      off    = 6'(b - base) + (fwd ? 6'(k) : 6'd26 - 6'(k));
      off    = (off >= 6'd26) ? off - 6'd26 : off;
      return (letter && (dir == DIR_FWD || dir == DIR_BWD)) ? base + 8'(off) : b;
   endfunction

endpackage

// File: rtl/cipher_lane.sv
// cipher_lane: one byte lane of the 3-stage datapath; each stage register keeps the
// controls that later stages still need so a stall freezes the whole beat.
module cipher_lane
   import cipher_pkg::*;
(
   input  logic       clock,
   input  logic       rst,
   input  logic       en_i,
   input  logic       mode_i,
   input  logic [1:0] dir_i,
   input  logic [4:0] shift_i,
   input  logic [7:0] din_i,
   input  logic [2:0] kidx_i,
   input  logic [7:0] key_i,
   output logic [2:0] kidx_o,
   output logic [7:0] dout_o
);

   logic [7:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic       m1_q, m2_q;
   logic [1:0] dir1_q, dir2_q;
   logic [4:0] sh1_q, sh2_q;
   logic [2:0] kidx1_q;

   always_comb begin
      s1_d = mode_i ? perm_inv(din_i) : caesar(din_i, dir_i, shift_i, 1'b0);
      s2_d = s1_q ^ key_i;
      s3_d = m2_q ? caesar(s2_q, dir2_q, sh2_q, 1'b1) : perm(s2_q);
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         s1_q    <= '0;
         s2_q    <= '0;
         s3_q    <= '0;
         m1_q    <= 1'b0;
         m2_q    <= 1'b0;
         dir1_q  <= '0;
         dir2_q  <= '0;
         sh1_q   <= '0;
         sh2_q   <= '0;
         kidx1_q <= '0;
      end else if (en_i) begin
         s1_q    <= s1_d;
         m1_q    <= mode_i;
         dir1_q  <= dir_i;
         sh1_q   <= shift_i;
         kidx1_q <= kidx_i;
         s2_q    <= s2_d;
         m2_q    <= m1_q;
         dir2_q  <= dir1_q;
         sh2_q   <= sh1_q;
         s3_q    <= s3_d;
      end
   end

   assign kidx_o = kidx1_q;
   assign dout_o = s3_q;

endmodule

// File: rtl/cipher_pipe.sv
// cipher_pipe: LANES-wide 3-stage cipher pipeline with rolling XOR keys; owns the key
// table, key pointer and the valid/ready control shared by all lanes.
module cipher_pipe
   import cipher_pkg::*;
#(
   parameter int LANES = 1,
   parameter int NKEY  = 3
) (
   input  logic               clock,
   input  logic               rst,
   input  logic               mode,
   input  logic [1:0]         direction,
   input  logic [4:0]         shift_num,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [8*LANES-1:0] din,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [8*LANES-1:0] dout,
   input  logic               key_we,
   input  logic [2:0]         key_idx,
   input  logic [7:0]         key_data,
   input  logic               key_sync
);

   logic [7:0] key_q [8];
   logic [2:0] ptr_q, ptr_d, base;
   logic [2:0] v_q, v_d;
   logic       adv, accept;

   // the whole pipe moves together, so only a full, unread last stage stalls it
   assign adv      = out_ready || !v_q[2];
   assign in_ready = adv && !rst;
   assign accept   = in_valid && in_ready;

   always_comb begin
      base  = key_sync ? 3'd0 : ptr_q;
      ptr_d = accept ? wrap(5'(base) + 5'(LANES), 5'(NKEY)) : base;
      v_d   = adv ? {v_q[1:0], accept} : v_q;
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         v_q   <= '0;
         ptr_q <= '0;
         for (int i = 0; i < 8; i++) key_q[i] <= KEY_DEFAULT[8*i +: 8];
      end else begin
         v_q   <= v_d;
         ptr_q <= ptr_d;
         if (key_we && int'(key_idx) < NKEY) key_q[key_idx] <= key_data;
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [2:0] kq;
      cipher_lane u_lane (
         .clock   (clock),
         .rst     (rst),
         .en_i    (adv),
         .mode_i  (mode),
         .dir_i   (direction),
         .shift_i (shift_num),
         .din_i   (din[8*g +: 8]),
         .kidx_i  (wrap(5'(base) + 5'(g), 5'(NKEY))),
         .key_i   (key_q[kq]),
         .kidx_o  (kq),
         .dout_o  (dout[8*g +: 8])
      );
   end

   assign out_valid = v_q[2];

endmodule

// File: tb/tb_cipher_pipe.sv
// tb_cipher_pipe: directed checks of a 1-lane and a 4-lane cipher_pipe against
// hand-computed ciphertext, plus an encrypt/decrypt round trip.
module tb_cipher_pipe;

   logic        clock = 1'b0;
   logic        rst = 1'b1, mode = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic        key_we = 1'b0, key_sync = 1'b0;
   logic [1:0]  direction = 2'b00;
   logic [4:0]  shift_num = 5'd0;
   logic [7:0]  din = 8'h00, key_data = 8'h00;
   logic [2:0]  key_idx = 3'd0;
   logic        in_ready, out_valid;
   logic [7:0]  dout;

   logic        w_in_valid = 1'b0, w_out_ready = 1'b1, w_key_we = 1'b0, w_key_sync = 1'b0;
   logic [31:0] w_din = 32'h0;
   logic [2:0]  w_key_idx = 3'd0;
   logic [7:0]  w_key_data = 8'h00;
   logic        w_in_ready, w_out_valid;
   logic [31:0] w_dout;

   int n_cmp = 0, n_bad = 0;

   always #5 clock = ~clock;

   cipher_pipe #(.LANES(1), .NKEY(3)) u1 (
      .clock(clock), .rst(rst), .mode(mode), .direction(direction), .shift_num(shift_num),
      .in_valid(in_valid), .in_ready(in_ready), .din(din),
      .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
      .key_we(key_we), .key_idx(key_idx), .key_data(key_data), .key_sync(key_sync));

   cipher_pipe #(.LANES(4), .NKEY(3)) u4 (
      .clock(clock), .rst(rst), .mode(mode), .direction(direction), .shift_num(shift_num),
      .in_valid(w_in_valid), .in_ready(w_in_ready), .din(w_din),
      .out_valid(w_out_valid), .out_ready(w_out_ready), .dout(w_dout),
      .key_we(w_key_we), .key_idx(w_key_idx), .key_data(w_key_data), .key_sync(w_key_sync));

   // lat counts edges after the accepting edge until out_valid; 2 means out_valid in
   // the third cycle after the acceptance cycle
   task automatic xfer1(input logic [7:0] d, input logic m, input logic [1:0] dr,
                        input logic [4:0] sh, input logic sy, output logic [7:0] q, output int lat);
      din = d; mode = m; direction = dr; shift_num = sh; key_sync = sy; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0; key_sync = 1'b0;
      lat = 99; q = 8'h00;
      for (int n = 1; n <= 8; n++) begin
         @(posedge clock); #1;
         if (out_valid) begin lat = n; q = dout; break; end
      end
   endtask

   task automatic xfer4(input logic [31:0] d, input logic sy, output logic [31:0] q, output int lat);
      w_din = d; mode = 1'b0; direction = 2'b00; shift_num = 5'd0; w_key_sync = sy; w_in_valid = 1'b1;
      @(posedge clock); #1;
      w_in_valid = 1'b0; w_key_sync = 1'b0;
      lat = 99; q = 32'h0;
      for (int n = 1; n <= 8; n++) begin
         @(posedge clock); #1;
         if (w_out_valid) begin lat = n; q = w_dout; break; end
      end
   endtask

   task automatic wkey(input logic [2:0] idx, input logic [7:0] data);
      key_we = 1'b1; key_idx = idx; key_data = data;
      @(posedge clock); #1;
      key_we = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (dout !== 8'h00) begin n_bad++; $display("FAIL reset_dout: got %h want 00", dout); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      n_cmp++; if (w_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_w_out_valid: got %b want 0", w_out_valid); end
      n_cmp++; if (w_dout !== 32'h0) begin n_bad++; $display("FAIL reset_w_dout: got %h want 0", w_dout); end
      rst = 1'b0;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
      @(posedge clock); #1;
   endtask

   task automatic test_encrypt;
      logic [7:0] q; int lat;
      xfer1(8'h41, 1'b0, 2'b01, 5'd3, 1'b0, q, lat);
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL encrypt_latency: got %0d want 2", lat); end
      n_cmp++; if (q !== 8'h57) begin n_bad++; $display("FAIL encrypt_41: got %h want 57", q); end
   endtask

   task automatic test_decrypt;
      logic [7:0] q; int lat;
      xfer1(8'h57, 1'b1, 2'b01, 5'd3, 1'b1, q, lat);
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL decrypt_latency: got %0d want 2", lat); end
      n_cmp++; if (q !== 8'h41) begin n_bad++; $display("FAIL decrypt_57: got %h want 41", q); end
   endtask

   task automatic test_caesar_bounds;
      logic [7:0] d [5] = '{8'h7A, 8'h35, 8'h61, 8'h41, 8'h41};
      logic [1:0] r [5] = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b11};
      logic [4:0] s [5] = '{5'd29, 5'd3, 5'd1, 5'd26, 5'd3};
      logic [7:0] e [5] = '{8'hB6, 8'h83, 8'h30, 8'hF7, 8'hF7};
      logic [7:0] q; int lat;
      for (int i = 0; i < 5; i++) begin
         xfer1(d[i], 1'b0, r[i], s[i], 1'b1, q, lat);
         n_cmp++; if (q !== e[i]) begin n_bad++; $display("FAIL caesar_vec%0d: got %h want %h", i, q, e[i]); end
      end
   endtask

   task automatic test_key_write;
      logic [7:0] q; int lat;
      wkey(3'd0, 8'h00);
      xfer1(8'h41, 1'b0, 2'b00, 5'd0, 1'b1, q, lat);
      n_cmp++; if (q !== 8'h90) begin n_bad++; $display("FAIL key_write: got %h want 90", q); end
   endtask

   task automatic test_lanes4;
      logic [31:0] e [4] = '{32'h67779267, 32'h92677792, 32'h67779267, 32'h92677792};
      logic        sy [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [31:0] q; int lat;
      for (int i = 0; i < 4; i++) begin
         xfer4(32'h0, sy[i], q, lat);
         n_cmp++; if (q !== e[i]) begin n_bad++; $display("FAIL lanes4_beat%0d: got %h want %h", i, q, e[i]); end
      end
   endtask

   task automatic test_rst_inflight;
      logic [7:0] e [3] = '{8'h67, 8'h92, 8'h77};
      logic [7:0] q; int lat;
      mode = 1'b0; direction = 2'b00; key_sync = 1'b0; out_ready = 1'b1;
      din = 8'hAA; in_valid = 1'b1;
      @(posedge clock); #1;
      din = 8'hBB;
      @(posedge clock); #1;
      in_valid = 1'b0; rst = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      @(posedge clock); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_flush_valid: got %b want 0", out_valid); end
      n_cmp++; if (dout !== 8'h00) begin n_bad++; $display("FAIL rst_flush_dout: got %h want 00", dout); end
      @(posedge clock); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_flush_valid2: got %b want 0", out_valid); end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         xfer1(8'h00, 1'b0, 2'b00, 5'd0, 1'b0, q, lat);
         n_cmp++; if (q !== e[i]) begin n_bad++; $display("FAIL default_key%0d: got %h want %h", i, q, e[i]); end
      end
   endtask

   task automatic test_roundtrip;
      logic [7:0] pt [100], ct [100];
      logic [1:0] dr [100];
      logic [4:0] sh [100];
      logic [7:0] q; int lat;
      for (int i = 0; i < 100; i++) begin
         pt[i] = 8'($urandom); dr[i] = 2'($urandom_range(0, 3)); sh[i] = 5'($urandom_range(0, 31));
      end
      for (int i = 0; i < 100; i++) begin
         xfer1(pt[i], 1'b0, dr[i], sh[i], i == 0, q, lat);
         ct[i] = q;
      end
      for (int i = 0; i < 100; i++) begin
         xfer1(ct[i], 1'b1, dr[i], sh[i], i == 0, q, lat);
         n_cmp++; if (q !== pt[i]) begin n_bad++; $display("FAIL roundtrip%0d: got %h want %h", i, q, pt[i]); end
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] tab [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
      logic [7:0] exp [8] = '{8'h80, 8'h01, 8'h20, 8'h02, 8'h04, 8'h40, 8'h10, 8'h08};
      int idx = 0, got = 0;
      logic saw_stall = 1'b0;
      wkey(3'd0, 8'h00); wkey(3'd1, 8'h00); wkey(3'd2, 8'h00);
      mode = 1'b0; direction = 2'b00; shift_num = 5'd0; key_sync = 1'b0;
      for (int c = 0; c < 30; c++) begin
         in_valid  = idx < 8;
         din       = (idx < 8) ? tab[idx] : 8'h00;
         out_ready = !(c >= 2 && c < 7);
         @(negedge clock);
         if (in_valid && !in_ready) saw_stall = 1'b1;
         if (out_valid && out_ready) begin
            n_cmp++;
            if (got >= 8) begin n_bad++; $display("FAIL b2b_extra: got %h want none", dout); end
            else if (dout !== exp[got]) begin n_bad++; $display("FAIL b2b_beat%0d: got %h want %h", got, dout, exp[got]); end
            got++;
         end
         if (in_valid && in_ready) idx++;
         @(posedge clock); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n_cmp++; if (saw_stall !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready_drop: got %b want 1", saw_stall); end
      n_cmp++; if (idx !== 8) begin n_bad++; $display("FAIL b2b_accepted: got %0d want 8", idx); end
      n_cmp++; if (got !== 8) begin n_bad++; $display("FAIL b2b_delivered: got %0d want 8", got); end
   endtask

   initial begin
      test_reset;
      test_encrypt;
      test_decrypt;
      test_caesar_bounds;
      test_key_write;
      test_lanes4;
      test_rst_inflight;
      test_roundtrip;
      test_back_to_back;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
